zap_mac_unit: RTL and testbench

Parametrised multi-cycle multiply-accumulate unit for the ZAP execute stage.
- Computes the full 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, optionally adding a 2·WIDTH-bit accumulator.
- Uses one (SLICE+1)×(SLICE+1) partial-product multiplier reused over (WIDTH/SLICE)² cycles.
- Supports long multiply (UMULL/SMULL/UMLAL/SMLAL) directly, unlike the previous 32-bit-only multiplier; sits beside the ALU and stalls it through `o_busy`.

---
 rtl/zap_mac_pkg.sv | 21 ++
 rtl/zap_mac_slice_pp.sv | 40 ++++
 rtl/zap_mac_unit.sv | 135 +++++++++++++
 tb/tb_zap_mac_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_mac_pkg.sv
// Shared types and helpers for the ZAP multi-cycle multiply-accumulate unit.
// Optional early termination is enabled with ZAP_MAC_EARLY_TERM_EN (see zap_mac_unit).
package zap_mac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      ACC,
      DONE
   } mac_state_t;

   function automatic int unsigned slice_count(input int unsigned width, input int unsigned slice);
      return width / slice;
   endfunction

   // Extension bit for a slice: only the top slice of a signed operand carries the sign.
   function automatic logic ext_bit(input logic msb, input logic top_slice, input logic is_signed);
      return msb & top_slice & is_signed;
   endfunction

endpackage

// File: rtl/zap_mac_slice_pp.sv
// Combinational partial product: selects slice i of rm and slice j of rs, extends both to
// SLICE+1 bits, multiplies them signed and places the product at bit SLICE*(i+j) of a 2*WIDTH word.
module zap_mac_slice_pp
   import zap_mac_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 16,
   parameter int unsigned IW    = 1
) (
   input  logic [WIDTH-1:0]   i_rm,
   input  logic [WIDTH-1:0]   i_rs,
   input  logic [IW-1:0]      i_i,
   input  logic [IW-1:0]      i_j,
   input  logic               i_signed,
   output logic [2*WIDTH-1:0] o_pp
);

   localparam int unsigned N  = slice_count(WIDTH, SLICE);
   localparam int unsigned PW = (2*WIDTH > 2*SLICE+2) ? 2*WIDTH : 2*SLICE+2;

   logic [SLICE-1:0]          a_sl;
   logic [SLICE-1:0]          b_sl;
   logic signed [SLICE:0]     a_ext;
   logic signed [SLICE:0]     b_ext;
   logic signed [2*SLICE+1:0] prod;
   logic signed [PW-1:0]      prod_w;
   logic [PW-1:0]             shifted;

   always_comb begin
      a_sl    = SLICE'(i_rm >> (SLICE * 32'(i_i)));
      b_sl    = SLICE'(i_rs >> (SLICE * 32'(i_j)));
      a_ext   = {ext_bit(a_sl[SLICE-1], 32'(i_i) == N-1, i_signed), a_sl};
      b_ext   = {ext_bit(b_sl[SLICE-1], 32'(i_j) == N-1, i_signed), b_sl};
      prod    = a_ext * b_ext;
      prod_w  = PW'(prod);
      shifted = prod_w << (SLICE * (32'(i_i) + 32'(i_j)));
      o_pp    = shifted[2*WIDTH-1:0];
   end

endmodule

// File: rtl/zap_mac_unit.sv
// Multi-cycle signed/unsigned long multiply-accumulate for the ZAP execute stage.
// Define ZAP_MAC_EARLY_TERM_EN to skip partial products of all-zero upper rs slices.
module zap_mac_unit
   import zap_mac_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clear_from_writeback,
   input  logic               i_data_stall,
   input  logic               i_clear_from_alu,
   input  logic               i_start,
   input  logic               i_signed,
   input  logic               i_accumulate,
   input  logic [WIDTH-1:0]   i_rm,
   input  logic [WIDTH-1:0]   i_rs,
   input  logic [WIDTH-1:0]   i_rh,
   input  logic [WIDTH-1:0]   i_rn,
   output logic [2*WIDTH-1:0] o_result,
   output logic               o_busy,
   output logic               o_done
);

   localparam int unsigned N  = slice_count(WIDTH, SLICE);
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   mac_state_t          state;
   logic [IW-1:0]       idx_i;
   logic [IW-1:0]       idx_j;
   logic [2*WIDTH-1:0]  x;
   logic [2*WIDTH-1:0]  pp;
   logic [2*WIDTH-1:0]  x_acc;
   logic [WIDTH-1:0]    rm_q;
   logic [WIDTH-1:0]    rs_q;
   logic [WIDTH-1:0]    rh_q;
   logic [WIDTH-1:0]    rn_q;
   logic                sgn_q;
   logic                acc_q;
   logic                skip;
   logic                row_end;

   zap_mac_slice_pp #(
      .WIDTH (WIDTH),
      .SLICE (SLICE),
      .IW    (IW)
   ) u_pp (
      .i_rm     (rm_q),
      .i_rs     (rs_q),
      .i_i      (idx_i),
      .i_j      (idx_j),
      .i_signed (sgn_q),
      .o_pp     (pp)
   );

   always_comb begin
      skip = 1'b0;
`ifdef ZAP_MAC_EARLY_TERM_EN
      // Remaining rs slices contribute nothing when they are zero and rs is not negative.
      skip = ((rs_q >> (SLICE * (32'(idx_j) + 1))) == '0) && (!sgn_q || !rs_q[WIDTH-1]);
`endif
      row_end = (idx_j == LAST) || skip;
      x_acc   = x + (acc_q ? {rh_q, rn_q} : '0);
      o_busy  = ((state == IDLE) && i_start) || (state == MUL) || (state == ACC);
      o_done  = (state == DONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         x        <= '0;
         idx_i    <= '0;
         idx_j    <= '0;
         rm_q     <= '0;
         rs_q     <= '0;
         rh_q     <= '0;
         rn_q     <= '0;
         sgn_q    <= 1'b0;
         acc_q    <= 1'b0;
         o_result <= '0;
      end else if (i_clear_from_writeback) begin
         state <= IDLE;
         x     <= '0;
      end else if (i_data_stall) begin
         state <= state;
      end else if (i_clear_from_alu) begin
         state <= IDLE;
         x     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  rm_q  <= i_rm;
                  rs_q  <= i_rs;
                  rh_q  <= i_rh;
                  rn_q  <= i_rn;
                  sgn_q <= i_signed;
                  acc_q <= i_accumulate;
                  x     <= '0;
                  idx_i <= '0;
                  idx_j <= '0;
                  state <= MUL;
               end
            end
            MUL: begin
               x <= x + pp;
               if (row_end) begin
                  idx_j <= '0;
                  if (idx_i == LAST) begin
                     state <= ACC;
                  end else begin
                     idx_i <= idx_i + 1'b1;
                  end
               end else begin
                  idx_j <= idx_j + 1'b1;
               end
            end
            ACC: begin
               x        <= x_acc;
               o_result <= x_acc;
               state    <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zap_mac_unit.sv
// Self-checking bench for zap_mac_unit: cycle-level reference model plus directed literal checks.
module tb_zap_mac_unit;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SLICE = 16;
   localparam int unsigned N     = WIDTH / SLICE;
   localparam int LAT_FULL = N*N + 2;
`ifdef ZAP_MAC_EARLY_TERM_EN
   localparam int LAT_SHORT = N + 2;
`else
   localparam int LAT_SHORT = N*N + 2;
`endif

   logic               clk;
   logic               i_reset;
   logic               i_clear_from_writeback;
   logic               i_data_stall;
   logic               i_clear_from_alu;
   logic               i_start;
   logic               i_signed;
   logic               i_accumulate;
   logic [WIDTH-1:0]   i_rm;
   logic [WIDTH-1:0]   i_rs;
   logic [WIDTH-1:0]   i_rh;
   logic [WIDTH-1:0]   i_rn;
   logic [2*WIDTH-1:0] o_result;
   logic               o_busy;
   logic               o_done;

   zap_mac_unit #(
      .WIDTH (WIDTH),
      .SLICE (SLICE)
   ) dut (
      .i_clk                  (clk),
      .i_reset                (i_reset),
      .i_clear_from_writeback (i_clear_from_writeback),
      .i_data_stall           (i_data_stall),
      .i_clear_from_alu       (i_clear_from_alu),
      .i_start                (i_start),
      .i_signed               (i_signed),
      .i_accumulate           (i_accumulate),
      .i_rm                   (i_rm),
      .i_rs                   (i_rs),
      .i_rh                   (i_rh),
      .i_rn                   (i_rn),
      .o_result               (o_result),
      .o_busy                 (o_busy),
      .o_done                 (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int t0     = 0;

   task automatic check(input string name, input logic [2*WIDTH-1:0] act, input logic [2*WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: full-width arithmetic on extended operands.
   function automatic logic [2*WIDTH-1:0] mac_ref(input logic [WIDTH-1:0] rm, input logic [WIDTH-1:0] rs,
                                                  input logic [WIDTH-1:0] rh, input logic [WIDTH-1:0] rn,
                                                  input logic sgn, input logic acc);
      logic [2*WIDTH-1:0] a;
      logic [2*WIDTH-1:0] b;
      a = sgn ? {{WIDTH{rm[WIDTH-1]}}, rm} : {{WIDTH{1'b0}}, rm};
      b = sgn ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
      return a * b + (acc ? {rh, rn} : '0);
   endfunction

   function automatic int op_latency(input logic [WIDTH-1:0] rs, input logic sgn);
`ifdef ZAP_MAC_EARLY_TERM_EN
      int top;
      logic [SLICE-1:0] s;
      if (sgn && rs[WIDTH-1]) return N*N + 2;
      top = 0;
      for (int k = 0; k < int'(N); k++) begin
         s = SLICE'(rs >> (SLICE * k));
         if (s != '0) top = k;
      end
      return N * (top + 1) + 2;
`else
      if (sgn && rs[WIDTH-1]) return N*N + 2;
      return N*N + 2;
`endif
   endfunction

   // Model: age counts non-stalled edges since the start cycle; age==lat is the done cycle.
   int                 age = -1;
   int                 lat = 0;
   logic [2*WIDTH-1:0] pend = '0;
   logic [2*WIDTH-1:0] mdl_result = '0;
   logic               mdl_valid = 1'b0;

   always @(posedge clk) begin
      if (i_reset) begin
         age = -1;
         mdl_result = '0;
         mdl_valid = 1'b1;
      end else if (i_clear_from_writeback) begin
         age = -1;
      end else if (i_data_stall) begin
         age = age;
      end else if (i_clear_from_alu) begin
         age = -1;
      end else if (age < 0) begin
         if (i_start) begin
            age  = 1;
            lat  = op_latency(i_rs, i_signed);
            pend = mac_ref(i_rm, i_rs, i_rh, i_rn, i_signed, i_accumulate);
         end
      end else if (age < lat) begin
         age++;
         if (age == lat) mdl_result = pend;
      end else begin
         age = -1;
      end
   end

   always @(negedge clk) begin
      if (mdl_valid) begin
         check("busy", 64'(o_busy), 64'((age < 0 && i_start) || (age >= 1 && age < lat)));
         check("done", 64'(o_done), 64'(age >= 1 && age == lat));
         check("result", o_result, mdl_result);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drives one start cycle, then scrambles the operand inputs to prove they were latched.
   task automatic start_op(input logic [WIDTH-1:0] rm, input logic [WIDTH-1:0] rs,
                           input logic [WIDTH-1:0] rh, input logic [WIDTH-1:0] rn,
                           input logic sgn, input logic acc);
      i_rm = rm; i_rs = rs; i_rh = rh; i_rn = rn;
      i_signed = sgn; i_accumulate = acc; i_start = 1'b1;
      t0 = cyc;
      tick();
      i_start = 1'b0;
      i_rm = ~rm; i_rs = ~rs; i_rh = ~rh; i_rn = ~rn;
      i_signed = ~sgn; i_accumulate = ~acc;
   endtask

   task automatic wait_done(input string name, input logic [2*WIDTH-1:0] exp, input int exp_cyc);
      int n;
      n = 0;
      while (!o_done && n < 100) begin
         tick();
         n++;
      end
      check({name, "_done"}, 64'(o_done), 64'(1));
      check({name, "_cyc"}, 64'(cyc - t0), 64'(exp_cyc));
      check({name, "_res"}, o_result, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      i_reset = 1'b1; i_clear_from_writeback = 1'b0; i_data_stall = 1'b0; i_clear_from_alu = 1'b0;
      i_start = 1'b0; i_signed = 1'b0; i_accumulate = 1'b0;
      i_rm = '0; i_rs = '0; i_rh = '0; i_rn = '0;
      tick();
      tick();
      i_reset = 1'b0;
      check("rst_result", o_result, 64'h0);
      check("rst_busy", 64'(o_busy), 64'(0));
      check("rst_done", 64'(o_done), 64'(0));

      start_op(32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 1'b0, 1'b0);
      wait_done("umul_max", 64'hFFFFFFFE_00000001, LAT_FULL);
      tick();
      start_op(32'h80000000, 32'h80000000, '0, '0, 1'b1, 1'b0);
      wait_done("smul_min", 64'h40000000_00000000, LAT_FULL);
      tick();
      start_op(32'hFFFFFFFF, 32'h00000002, '0, '0, 1'b1, 1'b0);
      wait_done("smul_neg1x2", 64'hFFFFFFFF_FFFFFFFE, LAT_SHORT);
      tick();
      start_op(32'h00000003, 32'hFFFFFFFB, 32'h0, 32'h10, 1'b1, 1'b1);
      wait_done("smlal", 64'h00000000_00000001, LAT_FULL);
      tick();
      start_op(32'h12345678, 32'h00000005, '0, '0, 1'b0, 1'b0);
      wait_done("umul_small", 64'h00000000_5B05B058, LAT_SHORT);
      tick();
      start_op(32'h00000005, 32'hFFFFFFFE, '0, '0, 1'b1, 1'b0);
      wait_done("smul_negrs", 64'hFFFFFFFF_FFFFFFF6, LAT_FULL);

      // Stall three cycles mid-MUL, then stall inside DONE.
      tick();
      start_op(32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 1'b0, 1'b0);
      tick();
      i_data_stall = 1'b1;
      tick(); tick(); tick();
      i_data_stall = 1'b0;
      wait_done("stall_mul", 64'hFFFFFFFE_00000001, LAT_FULL + 3);
      i_data_stall = 1'b1;
      tick();
      check("stall_done_hold1", 64'(o_done), 64'(1));
      tick();
      check("stall_done_hold2", 64'(o_done), 64'(1));
      i_data_stall = 1'b0;
      tick();
      check("stall_done_release", 64'(o_done), 64'(0));

      // clear_from_alu in cycle 3, new start in cycle 4.
      start_op(32'h00001234, 32'hFFFFFFFF, '0, '0, 1'b0, 1'b0);
      tick(); tick();
      i_clear_from_alu = 1'b1;
      tick();
      i_clear_from_alu = 1'b0;
      start_op(32'h00000007, 32'h80000001, '0, '0, 1'b0, 1'b0);
      wait_done("clr_alu_restart", 64'h00000003_80000007, LAT_FULL);

      // clear_from_writeback beats a simultaneous stall.
      tick();
      start_op(32'hDEADBEEF, 32'hFFFFFFFF, '0, '0, 1'b0, 1'b0);
      tick();
      i_clear_from_writeback = 1'b1; i_data_stall = 1'b1;
      tick();
      i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;
      check("wb_over_stall_busy", 64'(o_busy), 64'(0));
      for (int k = 0; k < 8; k++) begin
         tick();
         check("wb_abort_no_done", 64'(o_done), 64'(0));
      end

      // Stall beats a simultaneous clear_from_alu: op continues one cycle late.
      start_op(32'h00000007, 32'h00000009, '0, '0, 1'b0, 1'b0);
      i_clear_from_alu = 1'b1; i_data_stall = 1'b1;
      tick();
      i_clear_from_alu = 1'b0; i_data_stall = 1'b0;
      wait_done("stall_over_alu", 64'h00000000_0000003F, LAT_SHORT + 1);

      // Reset mid-operation zeroes the result.
      tick();
      start_op(32'h0000FFFF, 32'h0000FFFF, '0, '0, 1'b0, 1'b0);
      tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      check("rst_mid_result", o_result, 64'h0);
      check("rst_mid_busy", 64'(o_busy), 64'(0));
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
